mmio_bridge: RTL and testbench

Parametrised memory-mapped bridge between the CPU data port and its targets: a variable-latency DRAM and an on-chip peripheral window (LEDs, synchronised switches, timer). It sits between the core's load/store stage and memory. It replaces the fixed single-cycle DRAM/device coupling with a valid/ready handshake, so slow memory stalls the core. It adds a timeout watchdog and a compare-match timer with an interrupt output.

---
 rtl/mmio_pkg.sv | 26 ++
 rtl/mmio_timer.sv | 87 ++++++++
 rtl/mmio_bridge.sv | 190 +++++++++++++++++++
 tb/tb_mmio_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO bridge.
//   - Peripheral word offsets within the 4 KiB window
//   - TCTRL bit positions
//   - Bridge FSM state type
//   - Read data returned when a DRAM access times out
package mmio_pkg;

    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_TCNT  = 12'h020;
    localparam logic [11:0] OFF_TCMP  = 12'h024;
    localparam logic [11:0] OFF_TCTRL = 12'h028;
    localparam logic [11:0] OFF_ERR   = 12'h02C;

    localparam int TCTRL_EN  = 0;
    localparam int TCTRL_AR  = 1;
    localparam int TCTRL_IRQ = 8;

    typedef enum logic {
        IDLE      = 1'b0,
        DRAM_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: compare-match timer (TCNT/TCMP/TCTRL) with a sticky interrupt.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   wr_en             peripheral write strobe (already qualified by the bridge)
//   wr_off            word-aligned peripheral offset of the write
//   wr_data           write data
//   tcnt, tcmp        current counter / compare values (read-back)
//   tctrl             TCTRL read-back image (enable, auto-reload, irq)
//   irq               sticky interrupt
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en,
    input  logic [11:0] wr_off,
    input  logic [31:0] wr_data,
    output logic [31:0] tcnt,
    output logic [31:0] tcmp,
    output logic [31:0] tctrl,
    output logic        irq
);

    logic [31:0] tcnt_reg;
    logic [31:0] tcnt_next;
    logic [31:0] tcmp_reg;
    logic        en_reg;
    logic        ar_reg;
    logic        irq_reg;
    logic        match;
    logic        wr_tcnt;
    logic        wr_tcmp;
    logic        wr_tctrl;

    assign wr_tcnt  = wr_en && (wr_off == OFF_TCNT);
    assign wr_tcmp  = wr_en && (wr_off == OFF_TCMP);
    assign wr_tctrl = wr_en && (wr_off == OFF_TCTRL);

    assign match = en_reg && (tcnt_reg == tcmp_reg);

    // A CPU write to TCNT overrides both the increment and the auto-reload.
    always_comb begin
        tcnt_next = tcnt_reg;
        if (wr_tcnt) begin
            tcnt_next = wr_data;
        end else if (en_reg) begin
            tcnt_next = (match && ar_reg) ? 32'd0 : tcnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tcnt_reg <= '0;
            tcmp_reg <= '0;
            en_reg   <= 1'b0;
            ar_reg   <= 1'b0;
            irq_reg  <= 1'b0;
        end else begin
            tcnt_reg <= tcnt_next;
            if (wr_tcmp) begin
                tcmp_reg <= wr_data;
            end
            if (wr_tctrl) begin
                en_reg <= wr_data[TCTRL_EN];
                ar_reg <= wr_data[TCTRL_AR];
            end
            // A new match wins over a write-1-clear in the same cycle.
            if (match) begin
                irq_reg <= 1'b1;
            end else if (wr_tctrl && wr_data[TCTRL_IRQ]) begin
                irq_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        tctrl            = '0;
        tctrl[TCTRL_EN]  = en_reg;
        tctrl[TCTRL_AR]  = ar_reg;
        tctrl[TCTRL_IRQ] = irq_reg;
    end

    assign tcnt = tcnt_reg;
    assign tcmp = tcmp_reg;
    assign irq  = irq_reg;

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: valid/ready bridge from the CPU data port to a variable-latency
// DRAM and a peripheral window (LED, synchronised switches, timer, error reg).
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid/we/addr/wdata      CPU request, held stable until req_ready
//   req_ready, rdata             completion strobe and load data
//   dram_req/we/addr/wdata       DRAM request, held until dram_ack
//   dram_rdata, dram_ack         DRAM response
//   device_sw                    asynchronous switch inputs
//   device_led                   LED register
//   irq                          sticky timer interrupt
//   bus_err                      sticky error (timeout or unmapped access)
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          DRAM_AW     = 14,
    parameter logic [31:0] PERIPH_BASE = 32'hFFFF_F000,
    parameter int          SW_W        = 24,
    parameter int          LED_W       = 24,
    parameter int          TIMEOUT     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               req_ready,
    output logic [31:0]        rdata,
    output logic               dram_req,
    output logic               dram_we,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic               dram_ack,
    input  logic [SW_W-1:0]    device_sw,
    output logic [LED_W-1:0]   device_led,
    output logic               irq,
    output logic               bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t              state_reg;
    logic                dram_req_reg;
    logic                dram_we_reg;
    logic [DRAM_AW-1:0]  dram_addr_reg;
    logic [31:0]         dram_wdata_reg;
    logic [CW-1:0]       wait_cnt_reg;
    logic                bus_err_reg;
    logic [LED_W-1:0]    led_reg;
    logic [SW_W-1:0]     sw_meta_reg;
    logic [SW_W-1:0]     sw_sync_reg;

    logic        is_periph;
    logic [11:0] off;
    logic        periph_acc;
    logic        periph_wr;
    logic        dram_start;
    logic        dram_done;
    logic        dram_timeout;
    logic        mapped;
    logic [31:0] periph_rd;
    logic        err_set;
    logic        err_clr;

    logic [31:0] tcnt;
    logic [31:0] tcmp;
    logic [31:0] tctrl;

    // Byte-lane bits never take part in decoding.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    assign is_periph  = (req_addr[31:12] == PERIPH_BASE[31:12]);
    assign off        = {req_addr[11:2], 2'b00};
    assign periph_acc = (state_reg == IDLE) && req_valid && is_periph;
    assign periph_wr  = periph_acc && req_we;
    assign dram_start = (state_reg == IDLE) && req_valid && !is_periph;
    // An ack on the final wait cycle still counts as a normal completion.
    assign dram_done    = (state_reg == DRAM_WAIT) && dram_ack;
    assign dram_timeout = (state_reg == DRAM_WAIT) && !dram_ack && (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        periph_rd = '0;
        mapped    = 1'b1;
        case (off)
            OFF_LED:   periph_rd = 32'(led_reg);
            OFF_SW:    periph_rd = 32'(sw_sync_reg);
            OFF_TCNT:  periph_rd = tcnt;
            OFF_TCMP:  periph_rd = tcmp;
            OFF_TCTRL: periph_rd = tctrl;
            OFF_ERR:   periph_rd = {31'd0, bus_err_reg};
            default:   mapped    = 1'b0;
        endcase
    end

    always_comb begin
        req_ready = periph_acc || dram_done || dram_timeout;
        rdata     = '0;
        if (periph_acc) begin
            rdata = periph_rd;
        end else if (dram_done) begin
            rdata = dram_rdata;
        end else if (dram_timeout) begin
            rdata = TIMEOUT_PATTERN;
        end
    end

    assign err_set = (periph_acc && !mapped) || dram_timeout;
    assign err_clr = periph_wr && (off == OFF_ERR) && req_wdata[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            dram_req_reg   <= 1'b0;
            dram_we_reg    <= 1'b0;
            dram_addr_reg  <= '0;
            dram_wdata_reg <= '0;
            wait_cnt_reg   <= '0;
            bus_err_reg    <= 1'b0;
            led_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dram_start) begin
                        state_reg      <= DRAM_WAIT;
                        dram_req_reg   <= 1'b1;
                        dram_we_reg    <= req_we;
                        dram_addr_reg  <= req_addr[DRAM_AW+1:2];
                        dram_wdata_reg <= req_wdata;
                        wait_cnt_reg   <= '0;
                    end
                end
                DRAM_WAIT: begin
                    if (dram_done || dram_timeout) begin
                        state_reg    <= IDLE;
                        dram_req_reg <= 1'b0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (periph_wr && (off == OFF_LED)) begin
                led_reg <= req_wdata[LED_W-1:0];
            end

            // Setting wins over a write-1-clear in the same cycle.
            if (err_set) begin
                bus_err_reg <= 1'b1;
            end else if (err_clr) begin
                bus_err_reg <= 1'b0;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= device_sw;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    mmio_timer u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (periph_wr),
        .wr_off  (off),
        .wr_data (req_wdata),
        .tcnt    (tcnt),
        .tcmp    (tcmp),
        .tctrl   (tctrl),
        .irq     (irq)
    );

    assign dram_req   = dram_req_reg;
    assign dram_we    = dram_we_reg;
    assign dram_addr  = dram_addr_reg;
    assign dram_wdata = dram_wdata_reg;
    assign device_led = led_reg;
    assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed self-checking bench for mmio_bridge.
module tb_mmio_bridge;

    localparam int DRAM_AW = 14;
    localparam int SW_W    = 24;
    localparam int LED_W   = 24;
    localparam int TIMEOUT = 16;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               req_valid;
    logic               req_we;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic               req_ready;
    logic [31:0]        rdata;
    logic               dram_req;
    logic               dram_we;
    logic [DRAM_AW-1:0] dram_addr;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata;
    logic               dram_ack;
    logic [SW_W-1:0]    device_sw;
    logic [LED_W-1:0]   device_led;
    logic               irq;
    logic               bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mmio_bridge #(
        .DRAM_AW     (DRAM_AW),
        .PERIPH_BASE (32'hFFFF_F000),
        .SW_W        (SW_W),
        .LED_W       (LED_W),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rdata      (rdata),
        .dram_req   (dram_req),
        .dram_we    (dram_we),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .dram_ack   (dram_ack),
        .device_sw  (device_sw),
        .device_led (device_led),
        .irq        (irq),
        .bus_err    (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One peripheral access: drive at the falling edge, capture the
    // combinational response, commit on the next rising edge.
    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic rdy, output logic [31:0] rd);
        @(negedge clk_i);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        rdy = req_ready;
        rd  = rdata;
        @(posedge clk_i);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        $display("txn we=%0b addr=0x%08h wdata=0x%08h ready=%0b rdata=0x%08h", we, addr, wd, rdy, rd);
    endtask

    initial begin
        logic        rdy;
        logic [31:0] rd;

        rst_i      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        dram_rdata = '0;
        dram_ack   = 1'b0;
        device_sw  = '0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_dram_req", 32'(dram_req), 32'd0);
        chk("rst_dram_we", 32'(dram_we), 32'd0);
        chk("rst_dram_addr", 32'(dram_addr), 32'd0);
        chk("rst_dram_wdata", dram_wdata, 32'd0);
        chk("rst_led", 32'(device_led), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // LED store and read-back
        bus(1'b1, 32'hFFFF_F060, 32'h00AB_CDEF, rdy, rd);
        chk("led_wr_ready", 32'(rdy), 32'd1);
        chk("led_value", 32'(device_led), 32'h00AB_CDEF);
        bus(1'b0, 32'hFFFF_F060, 32'h0, rdy, rd);
        chk("led_rd_ready", 32'(rdy), 32'd1);
        chk("led_rd_data", rd, 32'h00AB_CDEF);

        // Switch synchroniser: one edge after the change is still old
        @(negedge clk_i);
        device_sw = 24'h5A_5A5A;
        bus(1'b0, 32'hFFFF_F070, 32'h0, rdy, rd);
        chk("sw_one_edge", rd, 32'h0);
        bus(1'b0, 32'hFFFF_F070, 32'h0, rdy, rd);
        chk("sw_two_edges", rd, 32'h005A_5A5A);

        // DRAM load, ack on the third cycle of dram_req -> completion in the
        // fourth cycle counting the request cycle as the first
        @(negedge clk_i);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010; req_wdata = 32'h0;
        #1;
        chk("dld_c1_ready", 32'(req_ready), 32'd0);
        @(posedge clk_i); #1;
        chk("dld_dram_req", 32'(dram_req), 32'd1);
        chk("dld_dram_addr", 32'(dram_addr), 32'd4);
        chk("dld_dram_we", 32'(dram_we), 32'd0);
        @(negedge clk_i); #1;
        chk("dld_c2_ready", 32'(req_ready), 32'd0);
        @(negedge clk_i); #1;
        chk("dld_c3_ready", 32'(req_ready), 32'd0);
        @(negedge clk_i);
        dram_ack = 1'b1; dram_rdata = 32'h1234_5678;
        #1;
        chk("dld_c4_ready", 32'(req_ready), 32'd1);
        chk("dld_rdata", rdata, 32'h1234_5678);
        @(posedge clk_i); #1;
        dram_ack = 1'b0; req_valid = 1'b0;
        chk("dld_req_drop", 32'(dram_req), 32'd0);
        $display("txn dram load addr=0x00000010 rdata=0x12345678");

        // DRAM store, best case: ack in the first wait cycle
        @(negedge clk_i);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0022; req_wdata = 32'hCAFE_F00D;
        @(posedge clk_i); #1;
        chk("dst_dram_we", 32'(dram_we), 32'd1);
        chk("dst_dram_addr", 32'(dram_addr), 32'd8);
        chk("dst_dram_wdata", dram_wdata, 32'hCAFE_F00D);
        @(negedge clk_i);
        dram_ack = 1'b1;
        #1;
        chk("dst_ready", 32'(req_ready), 32'd1);
        @(posedge clk_i); #1;
        dram_ack = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        $display("txn dram store addr=0x00000022 wdata=0xcafef00d");

        // Timeout: no ack, completion on the 16th wait cycle
        @(negedge clk_i);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100;
        @(posedge clk_i);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk_i); #1;
            if (k < TIMEOUT) begin
                chk($sformatf("to_wait%0d_ready", k), 32'(req_ready), 32'd0);
            end else begin
                chk("to_ready", 32'(req_ready), 32'd1);
                chk("to_rdata", rdata, 32'hDEAD_BEEF);
            end
        end
        @(posedge clk_i); #1;
        req_valid = 1'b0;
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_req_drop", 32'(dram_req), 32'd0);
        $display("txn dram load addr=0x00000100 timed out");
        // A late ack in IDLE is ignored
        @(negedge clk_i);
        dram_ack = 1'b1;
        #1;
        chk("late_ack_ready", 32'(req_ready), 32'd0);
        @(posedge clk_i); #1;
        dram_ack = 1'b0;
        chk("late_ack_no_req", 32'(dram_req), 32'd0);
        bus(1'b0, 32'hFFFF_F02C, 32'h0, rdy, rd);
        chk("err_rd", rd, 32'd1);
        bus(1'b1, 32'hFFFF_F02C, 32'h1, rdy, rd);
        chk("err_clear", 32'(bus_err), 32'd0);

        // Timer: TCMP=5, enable + auto-reload
        bus(1'b1, 32'hFFFF_F024, 32'd5, rdy, rd);
        bus(1'b1, 32'hFFFF_F028, 32'h3, rdy, rd);   // edge E0
        repeat (5) begin
            @(posedge clk_i);
        end
        #1;
        chk("tmr_irq_before", 32'(irq), 32'd0);
        bus(1'b0, 32'hFFFF_F020, 32'h0, rdy, rd);   // reads during cycle after E5
        chk("tmr_tcnt_match", rd, 32'd5);
        chk("tmr_irq_set", 32'(irq), 32'd1);
        bus(1'b0, 32'hFFFF_F020, 32'h0, rdy, rd);
        chk("tmr_reload", rd, 32'd0);
        bus(1'b1, 32'hFFFF_F028, 32'h103, rdy, rd); // clear irq, keep running
        chk("tmr_irq_clr", 32'(irq), 32'd0);
        repeat (3) begin
            @(posedge clk_i);
        end
        #1;
        chk("tmr_irq_wait", 32'(irq), 32'd0);
        @(posedge clk_i); #1;
        chk("tmr_irq_reset", 32'(irq), 32'd1);
        bus(1'b0, 32'hFFFF_F028, 32'h0, rdy, rd);
        chk("tmr_tctrl_rd", rd, 32'h0000_0103);
        bus(1'b1, 32'hFFFF_F028, 32'h100, rdy, rd); // disable, clear irq
        chk("tmr_irq_off", 32'(irq), 32'd0);

        // Timer wrap at 2^32 and TCNT write beating the increment
        bus(1'b1, 32'hFFFF_F020, 32'hFFFF_FFFF, rdy, rd);
        bus(1'b1, 32'hFFFF_F028, 32'h1, rdy, rd);
        bus(1'b0, 32'hFFFF_F020, 32'h0, rdy, rd);
        chk("tmr_max", rd, 32'hFFFF_FFFF);
        bus(1'b0, 32'hFFFF_F020, 32'h0, rdy, rd);
        chk("tmr_wrap", rd, 32'h0);
        bus(1'b1, 32'hFFFF_F020, 32'h100, rdy, rd);
        bus(1'b0, 32'hFFFF_F020, 32'h0, rdy, rd);
        chk("tmr_wr_wins", rd, 32'h100);
        bus(1'b1, 32'hFFFF_F028, 32'h0, rdy, rd);
        chk("tmr_no_irq", 32'(irq), 32'd0);

        // Unmapped peripheral read
        bus(1'b0, 32'hFFFF_F0F0, 32'h0, rdy, rd);
        chk("unmap_ready", 32'(rdy), 32'd1);
        chk("unmap_rdata", rd, 32'h0);
        chk("unmap_bus_err", 32'(bus_err), 32'd1);
        bus(1'b1, 32'hFFFF_F02C, 32'h1, rdy, rd);
        chk("unmap_err_clr", 32'(bus_err), 32'd0);

        // Asynchronous reset in the middle of DRAM_WAIT
        @(negedge clk_i);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
        @(posedge clk_i); #1;
        chk("rmid_req_up", 32'(dram_req), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rmid_req_drop", 32'(dram_req), 32'd0);
        chk("rmid_ready", 32'(req_ready), 32'd0);
        chk("rmid_led", 32'(device_led), 32'd0);
        req_valid = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        $display("txn reset during dram wait");
        // Back in IDLE: a peripheral access completes in its own cycle
        bus(1'b0, 32'hFFFF_F060, 32'h0, rdy, rd);
        chk("rmid_idle_ready", 32'(rdy), 32'd1);
        chk("rmid_idle_no_dram", 32'(dram_req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
